// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// Words are accepted over a load/ready handshake and sent one bit per enabled clock.
// A word waiting in the buffer starts right after the last bit of the current word.
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;

  logic             accept;
  logic             word_end;
  logic [WIDTH-1:0] sr_shifted;

  // Outputs decoded from state; ready is gated by rst so it is low while reset is held.
  always_comb begin
    ready     = rst && ((state_q == StIdle) || !buf_full_q);
    ser_valid = (state_q == StShift) && en;
    last      = ser_valid && (cnt_q == CntLast);
    busy      = (state_q == StShift) || buf_full_q;
    if (state_q == StShift) begin
      ser_out = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
    end else begin
      ser_out = IDLE_LEVEL;
    end
  end

  // Next-state: shift on enable, refill the shift register at word end without a gap.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    accept     = load && ready;
    word_end   = (state_q == StShift) && en && (cnt_q == CntLast);
    sr_shifted = LSB_FIRST ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d    = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (en) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + CntW'(1);
        end
        if (word_end) begin
          cnt_d = '0;
          if (buf_full_q) begin
            // ready is low here, so no new word can arrive on this edge.
            sr_d       = buf_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            sr_d = din;
          end else begin
            state_d = StIdle;
          end
        end else if (accept) begin
          buf_d      = din;
          buf_full_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any word in flight or buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4-bit LSB-first instance with a receiver model,
// and an 8-bit MSB-first instance.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       load, en;
  logic       ready, ser_out, ser_valid, last, busy;
  logic [7:0] din8;
  logic       load8, en8;
  logic       ready8, ser_out8, ser_valid8, last8, busy8;
  logic [3:0] rx;

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready), .en(en),
    .ser_out(ser_out), .ser_valid(ser_valid), .last(last), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .load(load8), .ready(ready8), .en(en8),
    .ser_out(ser_out8), .ser_valid(ser_valid8), .last(last8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: 4-bit shift register loading at the MSB and shifting right.
  always @(posedge clk or negedge rst) begin
    if (!rst) rx <= 4'b0;
    else if (ser_valid) rx <= {ser_out, rx[3:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  w;
  logic [7:0]  w8;
  logic [11:0] stream;
  logic [6:0]  en_pat, exp_pat;
  int          nvalid;

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b1; din = '0;
    load8 = 1'b0; en8 = 1'b1; din8 = '0;
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_last", last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single word 4'b1011, en held high.
    w = 4'hB;
    din = w; load = 1'b1;
    tick();
    load = 1'b0; din = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_bit", ser_out, w[i]);
      chk("t1_valid", ser_valid, 1);
      chk("t1_last", last, (i == 3));
      tick();
    end
    #1;
    chk("t1_idle_valid", ser_valid, 0);
    chk("t1_idle_line", ser_out, 0);
    chk("t1_idle_ready", ready, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_rx", rx, 4'hB);

    // Back-to-back A, 5 (buffered), then 3 held until the buffer drains.
    stream = 12'h35A;
    din = 4'hA; load = 1'b1;
    #1;
    chk("t2_ready0", ready, 1);
    tick();
    for (int i = 0; i < 12; i++) begin
      load = (i <= 4);
      din  = (i == 0) ? 4'h5 : 4'h3;
      #1;
      chk("t2_bit", ser_out, stream[i]);
      chk("t2_valid", ser_valid, 1);
      chk("t2_last", last, (i % 4 == 3));
      chk("t2_ready", ready, (i == 0 || i == 4 || i >= 8));
      tick();
    end
    load = 1'b0;
    #1;
    chk("t2_idle_valid", ser_valid, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_line", ser_out, 0);

    // 4'hC with enable toggled mid-word.
    en_pat  = 7'b1011001;
    exp_pat = 7'b1110000;
    nvalid  = 0;
    din = 4'hC; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = en_pat[i];
      #1;
      chk("t3_bit", ser_out, exp_pat[i]);
      chk("t3_valid", ser_valid, en_pat[i]);
      chk("t3_last", last, (i == 6));
      if (ser_valid) nvalid++;
      tick();
    end
    en = 1'b1;
    #1;
    chk("t3_nvalid", nvalid, 4);
    chk("t3_idle_valid", ser_valid, 0);
    chk("t3_idle_ready", ready, 1);

    // Reset during the third bit with a buffered word pending.
    din = 4'h6; load = 1'b1;
    tick();
    din = 4'h9;
    #1;
    chk("t4_ready_buf", ready, 1);
    tick();
    load = 1'b0;
    #1;
    chk("t4_busy", busy, 1);
    chk("t4_ready_full", ready, 0);
    tick();
    #1;
    chk("t4_bit3", ser_out, 1);
    rst = 1'b0;
    #1;
    chk("t4_rst_ready", ready, 0);
    chk("t4_rst_valid", ser_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_line", ser_out, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_after_valid", ser_valid, 0);
      chk("t4_after_line", ser_out, 0);
      chk("t4_after_ready", ready, 1);
      tick();
    end

    // 8-bit MSB-first instance, 8'h96.
    w8 = 8'h96;
    din8 = w8; load8 = 1'b1;
    #1;
    chk("t5_ready0", ready8, 1);
    tick();
    load8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_bit", ser_out8, w8[7 - i]);
      chk("t5_valid", ser_valid8, 1);
      chk("t5_last", last8, (i == 7));
      tick();
    end
    #1;
    chk("t5_idle_valid", ser_valid8, 0);
    chk("t5_idle_ready", ready8, 1);
    chk("t5_idle_line", ser_out8, 0);
    chk("t5_idle_busy", busy8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
